riscv_muldiv_issue: RTL and testbench
=====================================

Name: riscv_muldiv_issue

Overview:
Issue and scoreboard controller that sits between decode and the mul/div execution unit. It drives the unit's opcode interface and consumes its writeback interface, so it is the initiator end of that unit's protocol. It holds dependent instructions on RAW/WAW hazards against outstanding mul/div destinations. It retires writebacks into the register-file write port and flags protocol violations and hung operations.

Parameters:
MAX_OUTSTANDING, 2, max tracked in-flight ops with rd!=0 (range 1..3)
TIMEOUT, 64, cycles with ops outstanding and no writeback before timeout_o (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
dec_valid_i  in  1  decode presents an instruction
dec_muldiv_i  in  1  instruction is MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
dec_rd_idx_i  in  5  destination
dec_ra_idx_i  in  5  source A index
dec_rb_idx_i  in  5  source B index
dec_ra_operand_i  in  32  source A value
dec_rb_operand_i  in  32  source B value
dec_accept_o  out  1  instruction consumed this cycle
unit_valid_o  out  1  opcode valid to mul/div unit
unit_rd_idx_o  out  5  rd to unit
unit_ra_operand_o  out  32  operand A to unit
unit_rb_operand_o  out  32  operand B to unit
unit_stall_i  in  1  unit stall
unit_wb_idx_i  in  5  unit writeback index (0 = none)
unit_wb_value_i  in  32  unit writeback value
rf_wr_en_o  out  1  register-file write strobe
rf_wr_idx_o  out  5  register-file write index
rf_wr_value_o  out  32  register-file write data
pending_o  out  32  scoreboard, bit n = xn awaiting writeback
busy_o  out  1  outstanding count != 0
proto_err_o  out  1  sticky: writeback to non-pending index
timeout_o  out  1  sticky: watchdog expired
err_clr_i  in  1  clears proto_err_o and timeout_o

Behaviour:
- Reset (rst_ni low, async): pending=0, count=0, watchdog=0, rf_wr_en_o=0, rf_wr_idx_o=0, rf_wr_value_o=0, proto_err_o=0, timeout_o=0. Reset mid-operation discards all tracking. Late writebacks after reset raise proto_err_o.
- Hazard, combinational, evaluated against the registered scoreboard. haz = pending[ra] (ra!=0) | pending[rb] (rb!=0) | pending[rd] (rd!=0). There is no same-cycle bypass: a writeback clearing a bit unblocks the op on the next cycle.
- full = (count == MAX_OUTSTANDING) and rd!=0.
- issue = dec_valid_i & dec_muldiv_i & !haz & !full & !unit_stall_i.
- unit_valid_o = dec_valid_i & dec_muldiv_i & !haz & !full. This is combinational; the unit's stall decides acceptance.
- unit_rd_idx_o and the operand outputs are pass-throughs of the dec_* inputs.
- dec_accept_o = issue, or (dec_valid_i & !dec_muldiv_i) (non-muldiv ops are not this block's concern).
- On issue with rd!=0: pending[rd] is set and count increments at the next edge.
- On issue with rd==0: accepted but not tracked, since the unit produces no observable writeback for it.
- Writeback, when unit_wb_idx_i!=0:
  - If pending[idx] is set: clear it, decrement count, and register a write so that next cycle rf_wr_en_o=1, rf_wr_idx_o=idx, rf_wr_value_o=value. This is 1-cycle registered latency.
  - If pending[idx] is clear: set proto_err_o, perform no rf write, leave count unchanged.
- Simultaneous issue and writeback in one cycle: count += 1 - 1, so count is unchanged. The set and clear bits are always distinct because the WAW check forbids equal indices.
- rf_wr_en_o deasserts in any cycle following a cycle with no valid writeback.
- Watchdog:
  - Increments each cycle while count!=0 and no valid writeback.
  - Resets to 0 on any valid writeback or when count==0.
  - On reaching TIMEOUT it sets timeout_o and saturates.
- err_clr_i clears both sticky flags. A same-cycle set event wins over the clear.
- count never exceeds MAX_OUTSTANDING and never underflows. A protocol-error writeback does not decrement it.
- busy_o = count!=0. pending_o = scoreboard register.

Test Plan:
- MUL x5=x1*x2 (3*7) issued, no stall -> pending_o=0x20 next cycle; unit wb idx 5 value 21 -> rf_wr_en_o=1 idx 5 value 21 one cycle later, pending_o=0.
- DIV x6 in flight, then MUL with ra=x6 presented -> unit_valid_o=0 and dec_accept_o=0 until wb idx 6 is seen; accepted the cycle after.
- MAX_OUTSTANDING=2: MUL x3 and MUL x4 issued, third MUL x7 presented -> blocked by full. A wb to x3 in the same cycle does not unblock it; it is accepted the next cycle.
- unit_stall_i=1 with a hazard-free MUL x9 -> unit_valid_o=1, dec_accept_o=0, pending unchanged. Stall drops -> accepted, pending_o bit 9 set.
- wb idx 12 with pending=0 -> proto_err_o=1, rf_wr_en_o stays 0. err_clr_i pulse -> proto_err_o=0.
- DIV x8 issued, no wb for TIMEOUT=64 cycles -> timeout_o=1 at cycle 64. Assert rst_ni=0 mid-op -> all outputs 0, pending_o=0 immediately.

Source files
------------

// File: rtl/riscv_muldiv_issue.sv
// Issue/scoreboard controller between decode and the mul/div unit: blocks RAW/WAW
// hazards on in-flight destinations, retires writebacks and flags protocol/timeout faults.
module riscv_muldiv_issue #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dec_valid_i,
  input  logic        dec_muldiv_i,
  input  logic [4:0]  dec_rd_idx_i,
  input  logic [4:0]  dec_ra_idx_i,
  input  logic [4:0]  dec_rb_idx_i,
  input  logic [31:0] dec_ra_operand_i,
  input  logic [31:0] dec_rb_operand_i,
  output logic        dec_accept_o,
  output logic        unit_valid_o,
  output logic [4:0]  unit_rd_idx_o,
  output logic [31:0] unit_ra_operand_o,
  output logic [31:0] unit_rb_operand_o,
  input  logic        unit_stall_i,
  input  logic [4:0]  unit_wb_idx_i,
  input  logic [31:0] unit_wb_value_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_idx_o,
  output logic [31:0] rf_wr_value_o,
  output logic [31:0] pending_o,
  output logic        busy_o,
  output logic        proto_err_o,
  output logic        timeout_o,
  input  logic        err_clr_i
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0]      CNT_MAX = 2'(MAX_OUTSTANDING);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  logic [31:0]     pending_q;
  logic [1:0]      count_q;
  logic [WD_W-1:0] wd_q;

  logic haz, full, req, issue, track;
  logic wb_vld_p0, wb_err_p0, wd_run, wd_expire;
  logic [31:0] set_mask, clr_mask;

  // Hazards are checked against the registered scoreboard only; no same-cycle bypass.
  always_comb begin
    haz = ((dec_ra_idx_i != 5'd0) && pending_q[dec_ra_idx_i])
       || ((dec_rb_idx_i != 5'd0) && pending_q[dec_rb_idx_i])
       || ((dec_rd_idx_i != 5'd0) && pending_q[dec_rd_idx_i]);
    full  = (count_q == CNT_MAX) && (dec_rd_idx_i != 5'd0);
    req   = dec_valid_i && dec_muldiv_i && !haz && !full;
    issue = req && !unit_stall_i;
    track = issue && (dec_rd_idx_i != 5'd0);

    wb_vld_p0 = (unit_wb_idx_i != 5'd0) && pending_q[unit_wb_idx_i];
    wb_err_p0 = (unit_wb_idx_i != 5'd0) && !pending_q[unit_wb_idx_i];

    set_mask = track     ? (32'd1 << dec_rd_idx_i)  : 32'd0;
    clr_mask = wb_vld_p0 ? (32'd1 << unit_wb_idx_i) : 32'd0;

    wd_run    = (count_q != 2'd0) && !wb_vld_p0;
    wd_expire = wd_run && (wd_q == WD_MAX - 1'b1);
  end

  assign unit_valid_o      = req;
  assign dec_accept_o      = issue || (dec_valid_i && !dec_muldiv_i);
  assign unit_rd_idx_o     = dec_rd_idx_i;
  assign unit_ra_operand_o = dec_ra_operand_i;
  assign unit_rb_operand_o = dec_rb_operand_i;
  assign pending_o         = pending_q;
  assign busy_o            = (count_q != 2'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 32'd0;
      count_q   <= 2'd0;
      wd_q      <= '0;
    end else begin
      pending_q <= (pending_q | set_mask) & ~clr_mask;
      count_q   <= count_q + {1'b0, track} - {1'b0, wb_vld_p0};
      if (!wd_run)
        wd_q <= '0;
      else if (wd_q != WD_MAX)
        wd_q <= wd_q + 1'b1;
    end
  end

  // Writeback stage boundary: register-file write lands one cycle after the unit's writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_wr_en_o    <= 1'b0;
      rf_wr_idx_o   <= 5'd0;
      rf_wr_value_o <= 32'd0;
    end else begin
      rf_wr_en_o <= wb_vld_p0;
      if (wb_vld_p0) begin
        rf_wr_idx_o   <= unit_wb_idx_i;
        rf_wr_value_o <= unit_wb_value_i;
      end
    end
  end

  // Sticky flags: a same-cycle set event takes priority over err_clr_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      if (wb_err_p0)      proto_err_o <= 1'b1;
      else if (err_clr_i) proto_err_o <= 1'b0;
      if (wd_expire)      timeout_o   <= 1'b1;
      else if (err_clr_i) timeout_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_issue.sv
// Directed bench for riscv_muldiv_issue: issue, hazard, full, stall, protocol error,
// watchdog and asynchronous reset scenarios with hand-computed expectations.
module tb_riscv_muldiv_issue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dec_valid_i, dec_muldiv_i;
  logic [4:0]  dec_rd_idx_i, dec_ra_idx_i, dec_rb_idx_i;
  logic [31:0] dec_ra_operand_i, dec_rb_operand_i;
  logic        dec_accept_o, unit_valid_o;
  logic [4:0]  unit_rd_idx_o;
  logic [31:0] unit_ra_operand_o, unit_rb_operand_o;
  logic        unit_stall_i;
  logic [4:0]  unit_wb_idx_i;
  logic [31:0] unit_wb_value_i;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;
  logic [31:0] pending_o;
  logic        busy_o, proto_err_o, timeout_o, err_clr_i;

  int checks = 0;
  int errors = 0;

  riscv_muldiv_issue #(.MAX_OUTSTANDING(2), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dec_valid_i(dec_valid_i), .dec_muldiv_i(dec_muldiv_i),
    .dec_rd_idx_i(dec_rd_idx_i), .dec_ra_idx_i(dec_ra_idx_i), .dec_rb_idx_i(dec_rb_idx_i),
    .dec_ra_operand_i(dec_ra_operand_i), .dec_rb_operand_i(dec_rb_operand_i),
    .dec_accept_o(dec_accept_o), .unit_valid_o(unit_valid_o),
    .unit_rd_idx_o(unit_rd_idx_o), .unit_ra_operand_o(unit_ra_operand_o),
    .unit_rb_operand_o(unit_rb_operand_o), .unit_stall_i(unit_stall_i),
    .unit_wb_idx_i(unit_wb_idx_i), .unit_wb_value_i(unit_wb_value_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_idx_o(rf_wr_idx_o), .rf_wr_value_o(rf_wr_value_o),
    .pending_o(pending_o), .busy_o(busy_o), .proto_err_o(proto_err_o),
    .timeout_o(timeout_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    dec_valid_i = 0; dec_muldiv_i = 0;
    dec_rd_idx_i = 0; dec_ra_idx_i = 0; dec_rb_idx_i = 0;
    dec_ra_operand_i = 0; dec_rb_operand_i = 0;
    unit_stall_i = 0; unit_wb_idx_i = 0; unit_wb_value_i = 0; err_clr_i = 0;
  endtask

  task automatic present(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] a, input logic [31:0] b);
    dec_valid_i = 1; dec_muldiv_i = 1;
    dec_rd_idx_i = rd; dec_ra_idx_i = ra; dec_rb_idx_i = rb;
    dec_ra_operand_i = a; dec_rb_operand_i = b;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 0;
    #12;
    checks++;
    if (pending_o !== 32'd0 || busy_o !== 1'b0 || rf_wr_en_o !== 1'b0 || rf_wr_idx_o !== 5'd0 ||
        rf_wr_value_o !== 32'd0 || proto_err_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pend=%h busy=%b rfen=%b idx=%0d val=%h perr=%b tmo=%b required all 0",
               pending_o, busy_o, rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, proto_err_o, timeout_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
    step();
  endtask

  task automatic test_mul_wb();
    present(5, 1, 2, 32'd3, 32'd7);
    #1;
    checks++;
    if (unit_valid_o !== 1'b1 || dec_accept_o !== 1'b1 || unit_rd_idx_o !== 5'd5 ||
        unit_ra_operand_o !== 32'd3 || unit_rb_operand_o !== 32'd7) begin
      errors++;
      $display("FAIL mul_issue: uv=%b acc=%b rd=%0d a=%0d b=%0d required 1 1 5 3 7",
               unit_valid_o, dec_accept_o, unit_rd_idx_o, unit_ra_operand_o, unit_rb_operand_o);
    end
    step(); idle();
    checks++;
    if (pending_o !== 32'h20 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_pending: pend=%h busy=%b required 00000020 1", pending_o, busy_o);
    end
    unit_wb_idx_i = 5; unit_wb_value_i = 32'd21;
    #1;
    checks++;
    if (rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_latency: rf_wr_en=%b required 0", rf_wr_en_o);
    end
    step(); idle();
    checks++;
    if (rf_wr_en_o !== 1'b1 || rf_wr_idx_o !== 5'd5 || rf_wr_value_o !== 32'd21 ||
        pending_o !== 32'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_wb: en=%b idx=%0d val=%0d pend=%h busy=%b required 1 5 21 0 0",
               rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_o, busy_o);
    end
    step();
    checks++;
    if (rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_deassert: rf_wr_en=%b required 0", rf_wr_en_o);
    end
  endtask

  task automatic test_hazard();
    present(6, 1, 2, 32'd100, 32'd5);
    step(); idle();
    present(10, 6, 1, 32'd0, 32'd0);
    #1;
    checks++;
    if (unit_valid_o !== 1'b0 || dec_accept_o !== 1'b0) begin
      errors++;
      $display("FAIL raw_block: uv=%b acc=%b required 0 0", unit_valid_o, dec_accept_o);
    end
    step();
    unit_wb_idx_i = 6; unit_wb_value_i = 32'd20;
    #1;
    checks++;
    if (dec_accept_o !== 1'b0 || unit_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL raw_no_bypass: uv=%b acc=%b required 0 0", unit_valid_o, dec_accept_o);
    end
    step();
    unit_wb_idx_i = 0;
    #1;
    checks++;
    if (dec_accept_o !== 1'b1 || unit_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL raw_release: uv=%b acc=%b required 1 1", unit_valid_o, dec_accept_o);
    end
    step(); idle();
    checks++;
    if (pending_o !== 32'h400 || rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL raw_pending: pend=%h rfen=%b required 00000400 0", pending_o, rf_wr_en_o);
    end
    present(10, 0, 0, 32'd0, 32'd0);
    #1;
    checks++;
    if (dec_accept_o !== 1'b0 || unit_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL waw_block: uv=%b acc=%b required 0 0", unit_valid_o, dec_accept_o);
    end
    idle();
    unit_wb_idx_i = 10; unit_wb_value_i = 32'hABCD;
    step(); idle();
    step();
  endtask

  task automatic test_full();
    present(3, 1, 2, 32'd1, 32'd1);
    step();
    present(4, 1, 2, 32'd1, 32'd1);
    step();
    present(7, 1, 2, 32'd1, 32'd1);
    unit_wb_idx_i = 3; unit_wb_value_i = 32'd33;
    #1;
    checks++;
    if (dec_accept_o !== 1'b0 || unit_valid_o !== 1'b0 || pending_o !== 32'h18) begin
      errors++;
      $display("FAIL full_block: uv=%b acc=%b pend=%h required 0 0 00000018",
               unit_valid_o, dec_accept_o, pending_o);
    end
    step();
    unit_wb_idx_i = 0;
    #1;
    checks++;
    if (dec_accept_o !== 1'b1 || rf_wr_idx_o !== 5'd3 || rf_wr_value_o !== 32'd33) begin
      errors++;
      $display("FAIL full_release: acc=%b rfidx=%0d rfval=%0d required 1 3 33",
               dec_accept_o, rf_wr_idx_o, rf_wr_value_o);
    end
    step();
    present(0, 1, 2, 32'd1, 32'd1);
    #1;
    checks++;
    if (pending_o !== 32'h90 || dec_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL full_rd0: pend=%h acc=%b required 00000090 1", pending_o, dec_accept_o);
    end
    step(); idle();
    dec_valid_i = 1;
    #1;
    checks++;
    if (pending_o !== 32'h90 || dec_accept_o !== 1'b1 || unit_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL non_muldiv: pend=%h acc=%b uv=%b required 00000090 1 0",
               pending_o, dec_accept_o, unit_valid_o);
    end
    idle();
    unit_wb_idx_i = 4;
    step();
    unit_wb_idx_i = 7; unit_wb_value_i = 32'd77;
    step(); idle();
    checks++;
    if (pending_o !== 32'd0 || busy_o !== 1'b0 || rf_wr_idx_o !== 5'd7 || rf_wr_value_o !== 32'd77) begin
      errors++;
      $display("FAIL full_drain: pend=%h busy=%b idx=%0d val=%0d required 0 0 7 77",
               pending_o, busy_o, rf_wr_idx_o, rf_wr_value_o);
    end
    step();
  endtask

  task automatic test_stall();
    present(9, 1, 2, 32'd2, 32'd2);
    unit_stall_i = 1;
    #1;
    checks++;
    if (unit_valid_o !== 1'b1 || dec_accept_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: uv=%b acc=%b required 1 0", unit_valid_o, dec_accept_o);
    end
    step();
    checks++;
    if (pending_o !== 32'd0) begin
      errors++;
      $display("FAIL stall_pending: pend=%h required 0", pending_o);
    end
    unit_stall_i = 0;
    #1;
    checks++;
    if (dec_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: acc=%b required 1", dec_accept_o);
    end
    step(); idle();
    checks++;
    if (pending_o !== 32'h200) begin
      errors++;
      $display("FAIL stall_issue: pend=%h required 00000200", pending_o);
    end
    unit_wb_idx_i = 9;
    step(); idle();
    step();
  endtask

  task automatic test_proto_err();
    unit_wb_idx_i = 12; unit_wb_value_i = 32'd5;
    step(); idle();
    checks++;
    if (proto_err_o !== 1'b1 || rf_wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL proto_set: perr=%b rfen=%b busy=%b required 1 0 0", proto_err_o, rf_wr_en_o, busy_o);
    end
    err_clr_i = 1;
    step(); idle();
    checks++;
    if (proto_err_o !== 1'b0) begin
      errors++;
      $display("FAIL proto_clr: perr=%b required 0", proto_err_o);
    end
    err_clr_i = 1; unit_wb_idx_i = 12;
    step(); idle();
    checks++;
    if (proto_err_o !== 1'b1) begin
      errors++;
      $display("FAIL proto_set_wins: perr=%b required 1", proto_err_o);
    end
    err_clr_i = 1;
    step(); idle();
  endtask

  task automatic test_timeout();
    present(8, 1, 2, 32'd9, 32'd3);
    step(); idle();
    repeat (63) step();
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: tmo=%b required 0 after 63 cycles", timeout_o);
    end
    step();
    checks++;
    if (timeout_o !== 1'b1 || pending_o !== 32'h100) begin
      errors++;
      $display("FAIL timeout_set: tmo=%b pend=%h required 1 00000100", timeout_o, pending_o);
    end
    rst_ni = 0;
    #1;
    checks++;
    if (pending_o !== 32'd0 || busy_o !== 1'b0 || timeout_o !== 1'b0 || proto_err_o !== 1'b0 ||
        rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pend=%h busy=%b tmo=%b perr=%b rfen=%b required all 0",
               pending_o, busy_o, timeout_o, proto_err_o, rf_wr_en_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
    step();
    unit_wb_idx_i = 8; unit_wb_value_i = 32'd3;
    step(); idle();
    checks++;
    if (proto_err_o !== 1'b1 || rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL late_wb: perr=%b rfen=%b required 1 0", proto_err_o, rf_wr_en_o);
    end
  endtask

  initial begin
    test_reset();
    test_mul_wb();
    test_hazard();
    test_full();
    test_stall();
    test_proto_err();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
